// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        ON       = 2'd2,
        DONE     = 2'd3
    } div_state_e;

endpackage

// File: rtl/mips_div_step.sv
// One combinational restoring-division step on a {remainder, quotient} pair.
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // rem < div holds between steps, so a non-negative difference fits in WIDTH bits
    always_comb begin
        trial = {rem_i, quot_i[WIDTH-1]};
        diff  = trial - {1'b0, div_i};
        if (diff[WIDTH]) begin
            rem_o  = trial[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o  = diff[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mips_div.sv
// Iterative restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Define MIPS_DIV_EARLY_OUT_EN to finish immediately when |a| < |b|.
module mips_div
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   bmag_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               busy_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic [WIDTH-1:0]   step_rem_d;
    logic [WIDTH-1:0]   step_quot_d;
    logic [WIDTH-1:0]   fix_rem_d;
    logic [WIDTH-1:0]   fix_quot_d;
    logic               early_out_d;
    logic               ready_d;
    logic               busy_d;

    mips_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .div_i  (bmag_q),
        .rem_o  (step_rem_d),
        .quot_o (step_quot_d)
    );

    always_comb begin
        a_mag_d    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag_d    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        fix_quot_d = neg_quot_q ? -step_quot_d : step_quot_d;
        fix_rem_d  = neg_rem_q  ? -step_rem_d  : step_rem_d;
    end

`ifdef MIPS_DIV_EARLY_OUT_EN
    assign early_out_d = (a_mag_d < b_mag_d);
`else
    assign early_out_d = 1'b0;
`endif

    // Flags trail the state by one edge, which gives the documented ready latencies
    assign ready_d = (state_q == DONE) && start_i && !annul_i;
    assign busy_d  = ((state_q == ON) || (state_q == DIV_ZERO)) && !annul_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            bmag_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            result_q <= ready_d ? {rem_q, quot_q} : '0;
            if (annul_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (b_i == '0) begin
                                state_q <= DIV_ZERO;
                                quot_q  <= '1;
                                rem_q   <= a_i;
                            end else if (early_out_d) begin
                                state_q <= DONE;
                                quot_q  <= '0;
                                rem_q   <= a_i;
                            end else begin
                                state_q    <= ON;
                                rem_q      <= '0;
                                quot_q     <= a_mag_d;
                                bmag_q     <= b_mag_d;
                                neg_quot_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                neg_rem_q  <= signed_i && a_i[WIDTH-1];
                                cnt_q      <= '0;
                            end
                        end
                    end
                    DIV_ZERO: begin
                        state_q <= DONE;
                    end
                    ON: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DONE;
                            rem_q   <= fix_rem_d;
                            quot_q  <= fix_quot_d;
                        end else begin
                            rem_q   <= step_rem_d;
                            quot_q  <= step_quot_d;
                        end
                    end
                    DONE: begin
                        if (!start_i) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_mips_div.sv
// Directed bench for mips_div: arithmetic reference model, per-cycle result compare.
module tb_mips_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int          n_cmp;
    int          n_fail;
    logic [63:0] exp_res;
    bit          exp_valid;

    mips_div dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Reference: plain integer division, MIPS wrap on overflow, all-ones quotient on /0
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        if (b == 32'd0) return 2;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
`ifdef MIPS_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return 33;
`endif
        return 33;
    endfunction

    // Whenever ready_o is up the held result must match the model
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_o) begin
                if (!exp_valid) check("unexpected_ready", 64'(ready_o), 64'd0);
                else            check("result_cycle", result_o, exp_res);
            end
            if (busy_o && ready_o) check("busy_and_ready", 64'({busy_o, ready_o}), 64'd0);
        end
    end

    task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res);
        int cyc, bcnt, elat;
        elat      = model_lat(sg, a, b);
        exp_res   = model(sg, a, b);
        exp_valid = 1'b1;
        start_i   = 1'b1;
        signed_i  = sg;
        a_i       = a;
        b_i       = b;
        @(posedge clk); #1;
        a_i      = $urandom;
        b_i      = $urandom;
        signed_i = ~sg;
        cyc  = 0;
        bcnt = 0;
        while (!ready_o && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy_o) bcnt++;
        end
        res = result_o;
        $display("op sg=%0d a=%h b=%h -> result=%h latency=%0d busy=%0d",
                 sg, a, b, res, cyc, bcnt);
        check("latency", 64'(cyc), 64'(elat));
        check("busy_cycles", 64'(bcnt), 64'(elat - 1));
        repeat (2) begin @(posedge clk); #1; end
        check("ready_hold", 64'(ready_o), 64'd1);
        start_i = 1'b0;
        @(posedge clk); #1;
        check("ready_drop", 64'(ready_o), 64'd0);
        exp_valid = 1'b0;
    endtask

    localparam int NV = 12;
    bit          v_sg  [NV] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    logic [31:0] v_a   [NV] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd3,
                                32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                32'hFFFF_FFFF, 32'd1000000, 32'hFFFF_FFFD};
    logic [31:0] v_b   [NV] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd10,
                                32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0,
                                32'd1, 32'd1000, 32'd5};
    logic [63:0] v_exp [NV] = '{{32'h2, 32'hE}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'h0, 32'h8000_0000}, {32'h5, 32'hFFFF_FFFF},
                                {32'h3, 32'h0}, {32'h1, 32'hFFFF_FFFD},
                                {32'hFFFF_FFFE, 32'hE}, {32'h1, 32'h1},
                                {32'hFFFF_FFFB, 32'hFFFF_FFFF}, {32'h0, 32'hFFFF_FFFF},
                                {32'h0, 32'h3E8}, {32'hFFFF_FFFD, 32'h0}};

    initial begin
        logic [63:0] res;
        n_cmp     = 0;
        n_fail    = 0;
        exp_valid = 1'b0;
        exp_res   = '0;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        a_i       = '0;
        b_i       = '0;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            check("model_pin", model(v_sg[i], v_a[i], v_b[i]), v_exp[i]);
            do_op(v_sg[i], v_a[i], v_b[i], res);
            check("result_literal", res, v_exp[i]);
        end

        // Flush at iteration 10: no result for the dropped op
        exp_valid = 1'b0;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        a_i       = 32'd1000;
        b_i       = 32'd3;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        check("busy_before_annul", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_busy", 64'(busy_o), 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        $display("annul op dropped, ready=%0d busy=%0d", ready_o, busy_o);
        check("annul_no_ready", 64'(ready_o), 64'd0);
        do_op(1'b0, 32'd9, 32'd3, res);
        check("after_annul_result", res, {32'd0, 32'd3});

        // Asynchronous reset between edges during ON
        exp_valid = 1'b0;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        a_i       = 32'd1234;
        b_i       = 32'd5;
        repeat (5) begin @(posedge clk); #1; end
        check("busy_before_rst", 64'(busy_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-op: ready=%0d busy=%0d result=%h", ready_o, busy_o, result_o);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(1'b0, 32'd1234, 32'd5, res);
        check("after_rst_result", res, {32'd4, 32'd246});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_div.md
Name: mips_div

Overview:
- Iterative 32-bit restoring divider for the MIPS pipeline's DIV/DIVU instructions.
- Sits in the execute stage and produces the `div_ready` signal the hazard unit consumes to generate `stallD`/`stallE`.
- Holds its result stable until the pipeline releases the request; the result is then written to HI (remainder) and LO (quotient).

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  level request; high while a DIV/DIVU sits in the divider's stage and the pipeline is stalled on it.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU; sampled with start_i in IDLE.
- a_i  input  WIDTH  dividend (rs); sampled in IDLE.
- b_i  input  WIDTH  divisor (rt); sampled in IDLE.
- annul_i  input  1  pipeline flush/exception; aborts any operation.
- result_o  output  2*WIDTH  {remainder, quotient}; valid while ready_o is high.
- ready_o  output  1  the `div_ready` signal; high while the result is valid.
- busy_o  output  1  high in ON or DIV_ZERO.

Behaviour:
- Reset: rst high asynchronously forces state IDLE, counter 0, result_o 0, ready_o 0, busy_o 0.
- States: IDLE, DIV_ZERO, ON, DONE.
- IDLE, start_i=1, annul_i=0, b_i=0 -> DIV_ZERO.
- IDLE, start_i=1, annul_i=0, b_i≠0 -> ON. On this edge:
  - latch magnitudes |a|, |b| (two's-complement negate if signed_i and the MSB is set);
  - latch the signs and signed_i;
  - clear the counter.
- ON: one restoring step per cycle.
  - Shift {rem, quot} left by 1.
  - Trial-subtract |b| from the upper WIDTH+1 bits.
  - If the result is non-negative, keep the difference and set quot[0].
  - After 32 steps (counter 31) -> DONE.
- DONE entry, sign fix-up (signed only):
  - quotient negated if the operand signs differ;
  - remainder takes the dividend's sign.
- Latency: start_i accepted at edge t -> ready_o high after edge t+33.
- DIV_ZERO: one cycle, then DONE with quotient = all ones and remainder = a_i. ready_o is therefore high after edge t+2.
- DONE:
  - ready_o=1, result_o held stable.
  - Stays in DONE while start_i=1, so a held request never restarts.
  - start_i=0 -> IDLE next edge, ready_o drops.
- annul_i=1 in any state -> IDLE at the next edge, ready_o=0, result discarded. annul_i has priority over start_i.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no trap).
- Operand changes on a_i/b_i after acceptance are ignored.
- busy_o and ready_o are never high together.

Optional Feature:
- Macro: MIPS_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |a| < |b| (unsigned magnitude compare, b≠0) -> DONE directly with quotient 0 and remainder = a_i; ready_o is high after edge t+1.
- Undefined: every nonzero-divisor operation takes the full 33-cycle path. Results are identical either way.

Decomposition:
- Shared package (mips_div_pkg):
  - state enum (IDLE, DIV_ZERO, ON, DONE);
  - DIV_WIDTH = 32;
  - DIV_ITERS = 32.
- The DIV_CONTROL/DIVU_CONTROL codes remain in the existing defines file; the decoder drives signed_i from them.
- One natural sub-module: mips_div_step, a combinational single restoring step. Inputs: partial remainder/quotient and divisor. Outputs: next remainder/quotient.

Test Plan:
- DIVU 100 / 7, start held until ready -> ready_o after 33 cycles; result_o = {0x00000002, 0x0000000E}; ready_o drops one cycle after start_i falls.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; busy_o high for exactly 32 cycles.
- DIVU 5 / 0 -> ready_o after 2 cycles; result_o = {0x00000005, 0xFFFFFFFF}.
- annul_i pulse at iteration 10, then a new DIVU 9 / 3 -> first op dropped, no ready_o for it; second returns quotient 3, remainder 0 after 33 cycles.
- rst asserted mid-ON (async, between edges) -> ready_o/busy_o/result_o are 0 immediately. With MIPS_DIV_EARLY_OUT_EN: DIVU 3 / 10 -> ready_o after 1 cycle, {0x3, 0x0}.
